// File: rtl/ac_rle_sequencer.sv
// Zigzag AC run-length sequencer: buffers one coefficient block, queries an external
// last-non-zero scanner, then streams (run, coef) / ZRL / EOB symbols with a ready/valid handshake.
module ac_rle_sequencer #(
  parameter int unsigned MCU_SIZE      = 8,
  parameter int unsigned COEF_BITWIDTH = 12,
  parameter int unsigned IDX_BITWIDTH  = 6
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic [MCU_SIZE*MCU_SIZE*COEF_BITWIDTH-1:0]  i_data,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  output logic                                        o_scan_start,
  input  logic [IDX_BITWIDTH-1:0]                     i_scan_idx,
  input  logic                                        i_scan_valid,
  output logic [3:0]                                  o_run,
  output logic [COEF_BITWIDTH-1:0]                    o_coef,
  output logic                                        o_zrl,
  output logic                                        o_eob,
  output logic                                        o_valid,
  input  logic                                        i_ready
);

  localparam int unsigned N  = MCU_SIZE * MCU_SIZE;
  localparam int unsigned CW = COEF_BITWIDTH;
  localparam int unsigned IW = IDX_BITWIDTH;
  localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SCAN, S_EMIT, S_EOB} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [3:0]      r_q, r_d;
  logic [IW-1:0]   last_q, last_d;
  logic            valid_q, valid_d;
  logic [3:0]      run_q, run_d;
  logic [CW-1:0]   coef_q, coef_d;
  logic            zrl_q, zrl_d;
  logic            eob_q, eob_d;
  logic            ready_q, ready_d;
  logic            scan_start_q, scan_start_d;
  logic [CW-1:0]   blk_q [N];

  logic            accept;
  logic            hs;
  logic            examine;
  logic [IW-1:0]   cur_k;
  logic [3:0]      cur_r;

  assign accept = (state_q == S_IDLE) && ready_q && i_valid;
  assign hs     = valid_q && i_ready;

  // Block buffer keeps the coefficients stable for the scanner and the emitter.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < int'(N); i++) begin
        blk_q[i] <= i_data[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    last_d   = last_q;
    valid_d  = valid_q;
    run_d    = run_q;
    coef_d   = coef_q;
    zrl_d    = zrl_q;
    eob_d    = eob_q;
    cur_k    = k_q;
    cur_r    = r_q;
    examine  = 1'b0;

    case (state_q)
      S_IDLE: begin
        k_d = IW'(1);
        r_d = 4'd0;
        if (accept) state_d = S_START;
      end
      S_START: state_d = S_SCAN;
      S_SCAN: begin
        if (i_scan_valid) begin
          last_d = i_scan_idx;
          k_d    = IW'(1);
          r_d    = 4'd0;
          if (i_scan_idx == '0) begin
            state_d = S_EOB;
            valid_d = 1'b1;
            eob_d   = 1'b1;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        // An accepted symbol retires index k and the next index is examined in the same cycle.
        if (hs) begin
          if (k_q == last_q) begin
            valid_d = 1'b0;
            if (last_q == MAX_IDX) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_EOB;
              valid_d = 1'b1;
              eob_d   = 1'b1;
              zrl_d   = 1'b0;
              run_d   = 4'd0;
              coef_d  = '0;
            end
          end else begin
            cur_k   = IW'(k_q + 1'b1);
            cur_r   = 4'd0;
            examine = 1'b1;
          end
        end else if (!valid_q) begin
          examine = 1'b1;
        end

        if (examine) begin
          valid_d = 1'b0;
          k_d     = cur_k;
          r_d     = cur_r;
          if (blk_q[cur_k] == '0) begin
            if (cur_r == 4'd15) begin
              valid_d = 1'b1;
              zrl_d   = 1'b1;
              run_d   = 4'd15;
              coef_d  = '0;
            end else begin
              k_d = IW'(cur_k + 1'b1);
              r_d = 4'(cur_r + 4'd1);
            end
          end else begin
            valid_d = 1'b1;
            zrl_d   = 1'b0;
            run_d   = cur_r;
            coef_d  = blk_q[cur_k];
          end
        end
      end
      S_EOB: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Symbol fields read as zero whenever nothing is presented.
    if (!valid_d) begin
      run_d  = 4'd0;
      coef_d = '0;
      zrl_d  = 1'b0;
      eob_d  = 1'b0;
    end

    ready_d      = (state_d == S_IDLE);
    scan_start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      k_q          <= IW'(1);
      r_q          <= 4'd0;
      last_q       <= '0;
      valid_q      <= 1'b0;
      run_q        <= 4'd0;
      coef_q       <= '0;
      zrl_q        <= 1'b0;
      eob_q        <= 1'b0;
      ready_q      <= 1'b0;
      scan_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      r_q          <= r_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      run_q        <= run_d;
      coef_q       <= coef_d;
      zrl_q        <= zrl_d;
      eob_q        <= eob_d;
      ready_q      <= ready_d;
      scan_start_q <= scan_start_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_scan_start = scan_start_q;
  assign o_valid      = valid_q;
  assign o_run        = run_q;
  assign o_coef       = coef_q;
  assign o_zrl        = zrl_q;
  assign o_eob        = eob_q;

endmodule

// File: tb/tb_ac_rle_sequencer.sv
// Bench for ac_rle_sequencer: directed and random blocks compared against a run-length
// reference model built from the coefficient list.
module tb_ac_rle_sequencer;

  localparam int N  = 64;
  localparam int CW = 12;

  typedef int blk_t [N];

  logic              clk = 1'b0;
  logic              n_rst;
  logic [N*CW-1:0]   i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_scan_start;
  logic [5:0]        i_scan_idx;
  logic              i_scan_valid;
  logic [3:0]        o_run;
  logic [CW-1:0]     o_coef;
  logic              o_zrl;
  logic              o_eob;
  logic              o_valid;
  logic              i_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  ac_rle_sequencer #(.MCU_SIZE(8), .COEF_BITWIDTH(CW), .IDX_BITWIDTH(6)) dut (
    .clk(clk), .n_rst(n_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_scan_start(o_scan_start), .i_scan_idx(i_scan_idx), .i_scan_valid(i_scan_valid),
    .o_run(o_run), .o_coef(o_coef), .o_zrl(o_zrl), .o_eob(o_eob), .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sym(input bit eob, input bit zrl, input int run, input int coef);
    logic [3:0]    r4;
    logic [CW-1:0] c12;
    r4  = 4'(run);
    c12 = CW'(coef);
    return {14'd0, eob, zrl, r4, c12};
  endfunction

  function automatic logic [31:0] obs();
    return {14'd0, o_eob, o_zrl, o_run, o_coef};
  endfunction

  function automatic logic [N*CW-1:0] pack(input blk_t c);
    logic [N*CW-1:0] p;
    for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(c[i]);
    return p;
  endfunction

  // Reference: every 16th consecutive zero closes a ZRL; non-zeros close a (run, coef) pair.
  task automatic build_expect(input blk_t c, input int last);
    int run;
    run = 0;
    for (int k = 1; k <= last; k++) begin
      if (c[k] == 0) begin
        if (run == 15) begin
          exp_q.push_back(sym(0, 1, 15, 0));
          run = 0;
        end else begin
          run++;
        end
      end else begin
        exp_q.push_back(sym(0, 0, run, c[k]));
        run = 0;
      end
    end
    if (last < N - 1) exp_q.push_back(sym(1, 0, 0, 0));
  endtask

  task automatic run_block(input blk_t c, input int last, input int scan_dly, input int mode,
                           input int abort_after);
    logic [31:0] prev;
    bit pv, pr, done;
    int pops, n;
    exp_q.delete();
    build_expect(c, last);
    prev = '0;

    @(negedge clk);
    i_data       = pack(c);
    i_valid      = 1'b1;
    i_scan_valid = 1'b1;
    i_scan_idx   = 6'($urandom_range(1, 63));
    i_ready      = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(o_ready), 32'd1);

    @(negedge clk);
    check("scan_start", 32'(o_scan_start), 32'd1);
    i_valid      = 1'b0;
    i_data       = ~pack(c);
    i_scan_valid = 1'b1;
    i_scan_idx   = 6'($urandom_range(1, 63));

    @(negedge clk);
    check("scan_pulse_once", 32'(o_scan_start), 32'd0);
    i_scan_valid = 1'b0;
    repeat (scan_dly) @(negedge clk);
    i_scan_valid = 1'b1;
    i_scan_idx   = 6'(last);
    @(negedge clk);
    i_scan_valid = 1'b0;
    i_scan_idx   = 6'($urandom_range(0, 63));

    pv = 1'b0; pr = 1'b0; pops = 0; done = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (pv && !pr) begin
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_hold", obs(), prev);
      end
      if (!o_valid) check("idle_flags", 32'({o_zrl, o_eob}), 32'd0);
      if (exp_q.size() == 0 && o_ready) begin
        done = 1'b1;
      end else begin
        case (mode)
          0:       i_ready = 1'b1;
          1:       i_ready = (cyc % 2 == 0);
          default: i_ready = 1'($urandom_range(0, 1));
        endcase
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) check("extra_symbol", 32'(o_valid), 32'd0);
          else check("symbol", obs(), exp_q.pop_front());
          pops++;
        end
        pv = o_valid; pr = i_ready; prev = obs();
        if (abort_after >= 0 && pops == abort_after) begin
          @(negedge clk);
          n_rst = 1'b0;
          #1;
          check("abort_outputs_zero",
                32'({o_valid, o_ready, o_scan_start, o_zrl, o_eob, o_run, o_coef}), 32'd0);
          repeat (2) @(negedge clk);
          check("abort_still_quiet", 32'({o_valid, o_eob, o_coef}), 32'd0);
          n_rst = 1'b1;
          @(negedge clk);
          check("abort_ready_back", 32'(o_ready), 32'd1);
          exp_q.delete();
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    check("block_complete", 32'(done), 32'd1);
  endtask

  function automatic int rand_nz();
    int v;
    v = int'($urandom_range(1, 2047));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  initial begin
    blk_t c;
    int last, dens;
    n_rst = 1'b0; i_data = '0; i_valid = 1'b0; i_scan_idx = '0; i_scan_valid = 1'b0; i_ready = 1'b0;
    #1;
    check("rst_outputs",
          32'({o_valid, o_ready, o_scan_start, o_zrl, o_eob, o_run, o_coef}), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_outputs_held",
          32'({o_valid, o_ready, o_scan_start, o_zrl, o_eob, o_run, o_coef}), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(o_ready), 32'd1);

    c = '{default: 0}; c[0] = 50;
    run_block(c, 0, 3, 0, -1);

    c = '{default: 0}; c[0] = 9; c[1] = 3; c[4] = -2;
    run_block(c, 4, 0, 0, -1);

    c = '{default: 0}; c[20] = 7;
    run_block(c, 20, 1, 0, -1);

    c = '{default: 0}; c[63] = 1;
    run_block(c, 63, 2, 0, -1);

    c = '{default: 0}; c[1] = 3; c[4] = -2;
    run_block(c, 4, 0, 1, -1);

    c = '{default: 0}; c[20] = 7;
    run_block(c, 20, 2, 0, 1);
    c = '{default: 0}; c[1] = 3; c[4] = -2;
    run_block(c, 4, 1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      c = '{default: 0};
      c[0] = rand_nz();
      last = int'($urandom_range(0, 63));
      dens = int'($urandom_range(1, 12));
      for (int k = 1; k < last; k++)
        if ($urandom_range(0, dens - 1) == 0) c[k] = rand_nz();
      if (last > 0) c[last] = rand_nz();
      run_block(c, last, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_rle_sequencer.md
AC_RLE_SEQUENCER -- requirements
Module: ac_rle_sequencer

Interface
REQ-001 SHALL have parameter MCU_SIZE, default 8, MCU edge length; block holds MCU_SIZE*MCU_SIZE (N=64) zigzag-ordered coefficients.
REQ-002 SHALL have parameter COEF_BITWIDTH, default 12, signed quantized coefficient width.
REQ-003 SHALL have parameter IDX_BITWIDTH, default 6, width of a coefficient index (log2 N).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: n_rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: i_data  in  N*COEF_BITWIDTH  packed zigzag block, element 0 = DC.
REQ-007 SHALL have ports: i_valid  in  1  block offered; o_ready  out  1  block accepted when both high.
REQ-008 SHALL have ports: o_scan_start  out  1  one-cycle start pulse to the last-non-zero scanner.
REQ-009 SHALL have ports: i_scan_idx  in  IDX_BITWIDTH  last non-zero index L; i_scan_valid  in  1  L qualifier.
REQ-010 SHALL have ports: o_run  out  4  zero-run length; o_coef  out  COEF_BITWIDTH  coefficient value.
REQ-011 SHALL have ports: o_zrl  out  1  symbol is ZRL (16 zeros); o_eob  out  1  symbol is end-of-block.
REQ-012 SHALL have ports: o_valid  out  1  symbol valid; i_ready  in  1  downstream accepts when both high.

Function
REQ-013 SHALL implement states IDLE, START, SCAN, EMIT, EOB; o_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on i_valid&&o_ready SHALL latch i_data into an internal buffer, go to START.
REQ-015 START: SHALL drive o_scan_start=1 for exactly one cycle with i_data held stable by the buffer, go to SCAN.
REQ-016 SCAN: SHALL wait any number of cycles for i_scan_valid; on it latch L; L==0 -> EOB, else EMIT with pointer k=1, run counter r=0.
REQ-017 i_scan_valid outside SCAN SHALL be ignored.
REQ-018 EMIT: SHALL examine one coefficient buf[k] per advancing cycle; zero and r<15 -> r+=1, k+=1, no symbol.
REQ-019 EMIT: buf[k]==0 and r==15 -> present ZRL (o_run=15, o_coef=0, o_zrl=1), on handshake r=0, k+=1.
REQ-020 EMIT: buf[k]!=0 -> present (o_run=r, o_coef=buf[k]), on handshake r=0, k+=1.
REQ-021 After the symbol for k==L is accepted: L<N-1 -> EOB; L==N-1 -> IDLE with no EOB.
REQ-022 EOB: SHALL present o_eob=1, o_run=0, o_coef=0, o_zrl=0; on handshake go IDLE.
REQ-023 While o_valid&&!i_ready all symbol outputs and k, r SHALL hold unchanged (no drop, no duplicate).
REQ-024 ZRL SHALL only be emitted for k<L (guaranteed since buf[L]!=0); DC (element 0) SHALL never be emitted.
REQ-025 o_valid SHALL be registered; o_zrl, o_eob SHALL be 0 whenever o_valid=0; no combinational path i_ready->o_valid.
REQ-026 With i_ready held 1, a block SHALL consume at most 1 cycle per index 1..L plus 1 EOB cycle after scan completion.
REQ-027 A new block SHALL be accepted the cycle after return to IDLE at earliest.

Reset
REQ-028 n_rst=0 SHALL asynchronously force IDLE, k=1, r=0, buffer contents don't-care.
REQ-029 During reset: o_ready=0, o_scan_start=0, o_valid=0, o_run=0, o_coef=0, o_zrl=0, o_eob=0; o_ready=1 on the first clock after deassertion.
REQ-030 Reset mid-block SHALL abandon the block with no further symbols; next accepted block SHALL encode cleanly.

Verification
REQ-031 All-AC-zero block (DC=50), scanner returns L=0 -> exactly one symbol: EOB (run 0, coef 0).
REQ-032 buf[1]=3, buf[4]=-2, rest 0, L=4 -> (0,3), (2,-2), EOB; three handshakes.
REQ-033 buf[20]=7 only, L=20 -> ZRL(15,0), (3,7), EOB.
REQ-034 buf[63]=1 only, L=63 -> ZRL, ZRL, ZRL, (14,1), no EOB, o_ready returns high.
REQ-035 Case REQ-032 with i_ready toggled 1/0 every cycle -> identical symbol sequence, outputs stable while stalled.
REQ-036 Assert n_rst during EMIT of REQ-033 after ZRL -> outputs zero immediately, no (3,7) symbol; next block REQ-032 yields its exact sequence.
